gb_color_lut: RTL and testbench

//  Colour stage of the Green Beret video path. Per pixel it takes the layer-select plus 8-bit colour code from the

---
 rtl/gb_video_pkg.sv | 24 ++
 rtl/gb_dpram.sv | 38 +++
 rtl/gb_color_lut.sv | 123 ++++++++++++
 tb/tb_gb_color_lut.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_video_pkg.sv
// Shared constants, download-state encoding and palette byte expansion for the
// Green Beret colour path.
package gb_video_pkg;

    localparam logic [9:0] PAL_BASE = 10'h000;
    localparam logic [9:0] SPR_BASE = 10'h100;
    localparam logic [9:0] CHR_BASE = 10'h200;
    localparam logic [9:0] DL_LAST  = CHR_BASE + 10'h0FF;

    // EMPTY is the all-zero code so the power-up register value is a legal start state.
    typedef enum logic [1:0] {
        DL_EMPTY   = 2'd0,
        DL_FILLING = 2'd1,
        DL_READY   = 2'd2
    } dl_state_t;

    // BBGGGRRR -> {B,G,R} nibbles, replicating MSBs to fill the 4-bit DAC range.
    function automatic logic [11:0] expand_bbgggrrr(input logic [7:0] i_color);
        return {i_color[7:6], i_color[7:6],
                i_color[5:3], i_color[5],
                i_color[2:0], i_color[2]};
    endfunction

endpackage

// File: rtl/gb_dpram.sv
// Simple dual-port RAM: write port A, registered read port B with read enable.
module gb_dpram #(
    parameter int AW = 9,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    // NOTE: the array has no reset so it maps onto block RAM; only the read register clears.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // NOTE: non-blocking assignments mean a same-edge write is not yet visible here,
    // so an address collision returns the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/gb_color_lut.sv
// Colour stage: layer/code -> lookup PROM -> palette PROM -> 12-bit {B,G,R},
// with the PROM images loaded from the ROM download stream.
module gb_color_lut
    import gb_video_pkg::*;
(
    input  logic        clk48M,
    input  logic        reset,
    input  logic        PCE,
    input  logic [8:0]  PCODE,
    input  logic        PBLK,
    output logic [11:0] POUT,
    output logic        POUT_VLD,
    input  logic        ROMCL,
    input  logic [9:0]  ROMAD,
    input  logic [7:0]  ROMDT,
    input  logic        ROMEN,
    output logic        LOADED
);

    logic       w_pal_we;
    logic       w_spr_we;
    logic       w_chr_we;
    logic [8:0] w_lut_waddr;
    logic [4:0] w_pal_raddr;
    logic [3:0] w_s1_nib;
    logic [7:0] w_s2_color;
    logic       w_unused_romcl;

    dl_state_t   r_dl_state;
    logic        r_loaded;
    logic        r_s1_layer;
    logic        r_s1_blank;
    logic        r_s2_blank;
    logic [11:0] r_pout;
    logic        r_pout_vld;

    assign w_unused_romcl = ROMCL;

    assign w_pal_we    = ROMEN && (ROMAD[9:5] == PAL_BASE[9:5]);
    assign w_spr_we    = ROMEN && (ROMAD[9:8] == SPR_BASE[9:8]);
    assign w_chr_we    = ROMEN && (ROMAD[9:8] == CHR_BASE[9:8]);
    assign w_lut_waddr = {w_spr_we, ROMAD[7:0]};
    // Sprites own palette 0x00-0x0F, chars 0x10-0x1F.
    assign w_pal_raddr = {~r_s1_layer, w_s1_nib};

    gb_dpram #(.AW(9), .DW(4)) u_lut (
        .clk     (clk48M),
        .rst     (reset),
        .i_we    (w_spr_we || w_chr_we),
        .i_waddr (w_lut_waddr),
        .i_wdata (ROMDT[3:0]),
        .i_re    (PCE),
        .i_raddr (PCODE),
        .o_rdata (w_s1_nib)
    );

    gb_dpram #(.AW(5), .DW(8)) u_pal (
        .clk     (clk48M),
        .rst     (reset),
        .i_we    (w_pal_we),
        .i_waddr (ROMAD[4:0]),
        .i_wdata (ROMDT),
        .i_re    (PCE),
        .i_raddr (w_pal_raddr),
        .o_rdata (w_s2_color)
    );

    // Download tracking deliberately ignores reset: an image survives a video reset.
    always_ff @(posedge clk48M) begin
        if (ROMEN) begin
            case (r_dl_state)
                DL_EMPTY: begin
                    if (ROMAD == PAL_BASE) r_dl_state <= DL_FILLING;
                end
                DL_FILLING: begin
                    if (ROMAD == DL_LAST) begin
                        r_dl_state <= DL_READY;
                        r_loaded   <= 1'b1;
                    end
                end
                DL_READY: begin
                    if (ROMAD == PAL_BASE) begin
                        r_dl_state <= DL_FILLING;
                        r_loaded   <= 1'b0;
                    end
                end
                default: begin
                    r_dl_state <= DL_EMPTY;
                    r_loaded   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk48M or posedge reset) begin
        if (reset) begin
            r_s1_layer <= 1'b0;
            r_s1_blank <= 1'b0;
            r_s2_blank <= 1'b0;
            r_pout     <= 12'h000;
            r_pout_vld <= 1'b0;
        end else begin
            if (PCE) begin
                r_s1_layer <= PCODE[8];
                r_s1_blank <= PBLK;
                // Sprite nibble 0 is transparent and folds into the blank flag.
                r_s2_blank <= r_s1_blank || (r_s1_layer && (w_s1_nib == 4'h0));
            end
            if (!r_loaded) begin
                r_pout     <= 12'h000;
                r_pout_vld <= 1'b0;
            end else if (PCE) begin
                r_pout     <= r_s2_blank ? 12'h000 : expand_bbgggrrr(w_s2_color);
                r_pout_vld <= !r_s2_blank;
            end
        end
    end

    assign POUT     = r_pout;
    assign POUT_VLD = r_pout_vld;
    assign LOADED   = r_loaded;

endmodule

// File: tb/tb_gb_color_lut.sv
// Self-checking bench for gb_color_lut against a behavioural PROM/palette model.
module tb_gb_color_lut;

    typedef struct packed {
        logic [11:0] pout;
        logic        vld;
        logic        care;
    } exp_t;

    logic        clk48M = 1'b0;
    logic        reset  = 1'b0;
    logic        PCE    = 1'b0;
    logic [8:0]  PCODE  = 9'h000;
    logic        PBLK   = 1'b0;
    logic [11:0] POUT;
    logic        POUT_VLD;
    logic        ROMCL;
    logic [9:0]  ROMAD  = 10'h000;
    logic [7:0]  ROMDT  = 8'h00;
    logic        ROMEN  = 1'b0;
    logic        LOADED;

    int n_err = 0;
    int n_chk = 0;

    logic [7:0] m_pal [32];
    logic [3:0] m_lut [512];
    bit         m_loaded = 1'b0;
    int         m_state  = 0;   // 0 empty, 1 filling, 2 ready
    exp_t       q[$];
    exp_t       hold;
    bit         hold_valid = 1'b0;

    assign ROMCL = clk48M;

    gb_color_lut dut (
        .clk48M   (clk48M),
        .reset    (reset),
        .PCE      (PCE),
        .PCODE    (PCODE),
        .PBLK     (PBLK),
        .POUT     (POUT),
        .POUT_VLD (POUT_VLD),
        .ROMCL    (ROMCL),
        .ROMAD    (ROMAD),
        .ROMDT    (ROMDT),
        .ROMEN    (ROMEN),
        .LOADED   (LOADED)
    );

    always #10 clk48M = ~clk48M;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    // Colour a pixel should show, from the current PROM images and load status.
    function automatic exp_t model_px(input logic [8:0] pc, input bit blk);
        exp_t e;
        int c, r, g, b;
        logic [3:0] nib;
        e   = '{pout: 12'h000, vld: 1'b0, care: 1'b1};
        nib = m_lut[pc];
        if (!m_loaded || blk || (pc[8] && nib == 4'h0)) return e;
        c = int'(m_pal[{~pc[8], nib}]);
        r = c % 8;
        g = (c / 8) % 8;
        b = c / 64;
        e.pout = 12'((b * 5) * 256 + (g * 2 + g / 4) * 16 + (r * 2 + r / 4));
        e.vld  = 1'b1;
        return e;
    endfunction

    task automatic pipe_unknown();
        q.delete();
        q.push_back('0);
        q.push_back('0);
        hold_valid = 1'b0;
    endtask

    // One clock: optional pixel sample and optional download write. Returns the
    // expectation for the output after this edge, and whether it is meaningful.
    task automatic step(input bit pce, input logic [8:0] pc, input bit blk,
                        input bit we, input logic [9:0] wa, input logic [7:0] wd,
                        output bit cmp, output exp_t e);
        exp_t s;
        bit   was_loaded;
        PCE = pce; PCODE = pc; PBLK = blk; ROMEN = we; ROMAD = wa; ROMDT = wd;
        was_loaded = m_loaded;
        // The palette is read one PCE after sampling, so a write on the sample edge is seen.
        if (we && wa < 10'h020) m_pal[wa[4:0]] = wd;
        if (pce) begin
            s = model_px(pc, blk);
            q.push_back(s);
        end
        if (we) begin
            if (wa >= 10'h100 && wa < 10'h300) m_lut[{wa < 10'h200, wa[7:0]}] = wd[3:0];
            if (wa == 10'h000) begin
                m_state  = 1;
                m_loaded = 1'b0;
            end else if (wa == 10'h2FF && m_state == 1) begin
                m_state  = 2;
                m_loaded = 1'b1;
            end
            hold_valid = 1'b0;
        end
        if (m_loaded != was_loaded) foreach (q[i]) q[i].care = 1'b0;
        @(posedge clk48M);
        #1;
        PCE = 1'b0; ROMEN = 1'b0;
        cmp = 1'b0;
        e   = '0;
        if (pce) begin
            e          = q.pop_front();
            cmp        = e.care;
            hold       = e;
            hold_valid = e.care;
        end else if (hold_valid) begin
            e   = hold;
            cmp = 1'b1;
        end
    endtask

    task automatic rom_wr(input logic [9:0] a, input logic [7:0] d);
        bit   c;
        exp_t x;
        step(1'b0, 9'h000, 1'b0, 1'b1, a, d, c, x);
    endtask

    // Sample one pixel, then two blank pixels so it reaches POUT.
    task automatic run_pixel(input logic [8:0] pc, input bit blk, output bit cmp, output exp_t e);
        bit   c;
        exp_t x;
        step(1'b1, pc, blk, 1'b0, 10'h000, 8'h00, c, x);
        step(1'b1, 9'($urandom), 1'b1, 1'b0, 10'h000, 8'h00, c, x);
        step(1'b1, 9'($urandom), 1'b1, 1'b0, 10'h000, 8'h00, cmp, e);
    endtask

    task automatic test_powerup();
        repeat (3) @(posedge clk48M);
        #1;
        n_chk++;
        if (LOADED !== 1'b0) begin
            n_err++;
            $display("FAIL powerup_loaded: LOADED=%b expected 0", LOADED);
        end
        n_chk++;
        if (POUT !== 12'h000 || POUT_VLD !== 1'b0) begin
            n_err++;
            $display("FAIL powerup_pout: POUT=%h VLD=%b expected 000/0", POUT, POUT_VLD);
        end
    endtask

    task automatic test_reset();
        bit   cmp;
        exp_t e;
        reset = 1'b1;
        #3;
        n_chk++;
        if (POUT !== 12'h000 || POUT_VLD !== 1'b0 || LOADED !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: POUT=%h VLD=%b LOADED=%b expected 000/0/0", POUT, POUT_VLD, LOADED);
        end
        @(posedge clk48M);
        #1;
        reset = 1'b0;
        pipe_unknown();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 9'($urandom), 1'($urandom), 1'b0, 10'h000, 8'h00, cmp, e);
            if (cmp) begin
                n_chk++;
                if (POUT !== e.pout || POUT_VLD !== e.vld) begin
                    n_err++;
                    $display("FAIL unloaded_black[%0d]: POUT=%h VLD=%b expected %h/%b", i, POUT, POUT_VLD, e.pout, e.vld);
                end
            end
        end
    endtask

    task automatic test_download_fill();
        bit         cmp;
        exp_t       e;
        logic [7:0] d;
        for (int a = 0; a < 'h2FF; a++) begin
            if (a >= 'h20 && a < 'h100) continue;
            d = 8'($urandom);
            if (a == 'h013) d = 8'hFF;
            if (a == 'h205) d = 8'h03;
            rom_wr(10'(a), d);
        end
        n_chk++;
        if (LOADED !== 1'b0) begin
            n_err++;
            $display("FAIL loaded_early: LOADED=%b expected 0 before last byte", LOADED);
        end
        rom_wr(10'h2FF, 8'($urandom));
        n_chk++;
        if (LOADED !== 1'b1) begin
            n_err++;
            $display("FAIL loaded_done: LOADED=%b expected 1", LOADED);
        end
        run_pixel(9'h005, 1'b0, cmp, e);
        n_chk++;
        if (!cmp || POUT !== 12'hFFF || POUT_VLD !== 1'b1 || e.pout !== POUT) begin
            n_err++;
            $display("FAIL char_white: POUT=%h VLD=%b expected FFF/1", POUT, POUT_VLD);
        end
    endtask

    task automatic test_transparent();
        bit   cmp;
        exp_t e;
        rom_wr(10'h120, 8'h00);
        run_pixel(9'h120, 1'b0, cmp, e);
        n_chk++;
        if (!cmp || POUT !== 12'h000 || POUT_VLD !== 1'b0 || e.vld !== 1'b0) begin
            n_err++;
            $display("FAIL sprite_transparent: POUT=%h VLD=%b expected 000/0", POUT, POUT_VLD);
        end
        rom_wr(10'h120, 8'h01);
        rom_wr(10'h001, 8'h07);
        run_pixel(9'h120, 1'b0, cmp, e);
        n_chk++;
        if (!cmp || POUT !== 12'h00F || POUT_VLD !== 1'b1 || e.pout !== 12'h00F) begin
            n_err++;
            $display("FAIL sprite_red: POUT=%h VLD=%b expected 00F/1", POUT, POUT_VLD);
        end
        run_pixel(9'h005, 1'b1, cmp, e);
        n_chk++;
        if (!cmp || POUT !== 12'h000 || POUT_VLD !== 1'b0) begin
            n_err++;
            $display("FAIL blanked: POUT=%h VLD=%b expected 000/0", POUT, POUT_VLD);
        end
    endtask

    task automatic test_pce_hold();
        bit   cmp;
        exp_t e;
        step(1'b1, 9'h005, 1'b0, 1'b0, 10'h000, 8'h00, cmp, e);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 20; i++) begin
                step(1'b0, 9'($urandom), 1'($urandom), 1'b0, 10'h000, 8'h00, cmp, e);
                if (cmp) begin
                    n_chk++;
                    if (POUT !== e.pout || POUT_VLD !== e.vld) begin
                        n_err++;
                        $display("FAIL hold[%0d.%0d]: POUT=%h VLD=%b expected %h/%b", k, i, POUT, POUT_VLD, e.pout, e.vld);
                    end
                end
            end
            if (k < 2) step(1'b1, 9'($urandom), 1'b1, 1'b0, 10'h000, 8'h00, cmp, e);
        end
        n_chk++;
        if (POUT !== 12'hFFF || POUT_VLD !== 1'b1) begin
            n_err++;
            $display("FAIL hold_third_pce: POUT=%h VLD=%b expected FFF/1", POUT, POUT_VLD);
        end
    endtask

    task automatic test_random_stream();
        bit   cmp;
        exp_t e;
        for (int i = 0; i < 150; i++) begin
            step(1'b1, 9'($urandom), ($urandom_range(0, 3) == 0), 1'b0, 10'h000, 8'h00, cmp, e);
            if (cmp) begin
                n_chk++;
                if (POUT !== e.pout || POUT_VLD !== e.vld) begin
                    n_err++;
                    $display("FAIL stream[%0d]: POUT=%h VLD=%b expected %h/%b", i, POUT, POUT_VLD, e.pout, e.vld);
                end
            end
            repeat ($urandom_range(0, 3)) begin
                step(1'b0, 9'($urandom), 1'($urandom), 1'b0, 10'h000, 8'h00, cmp, e);
                if (cmp) begin
                    n_chk++;
                    if (POUT !== e.pout || POUT_VLD !== e.vld) begin
                        n_err++;
                        $display("FAIL stream_idle[%0d]: POUT=%h VLD=%b expected %h/%b", i, POUT, POUT_VLD, e.pout, e.vld);
                    end
                end
            end
        end
    endtask

    task automatic test_write_race();
        bit   cmp;
        exp_t e;
        rom_wr(10'h207, 8'h00);
        rom_wr(10'h010, 8'h2A);
        step(1'b1, 9'h007, 1'b0, 1'b0, 10'h000, 8'h00, cmp, e);
        step(1'b1, 9'h007, 1'b0, 1'b1, 10'h010, 8'hC5, cmp, e);
        step(1'b1, 9'h000, 1'b1, 1'b0, 10'h000, 8'h00, cmp, e);
        n_chk++;
        if (!cmp || POUT !== 12'h0B4 || POUT_VLD !== 1'b1 || e.pout !== POUT) begin
            n_err++;
            $display("FAIL race_old: POUT=%h VLD=%b expected 0B4/1", POUT, POUT_VLD);
        end
        step(1'b1, 9'h000, 1'b1, 1'b0, 10'h000, 8'h00, cmp, e);
        n_chk++;
        if (!cmp || POUT !== 12'hF0B || POUT_VLD !== 1'b1 || e.pout !== POUT) begin
            n_err++;
            $display("FAIL race_new: POUT=%h VLD=%b expected F0B/1", POUT, POUT_VLD);
        end
    endtask

    task automatic test_ignored();
        bit   cmp;
        exp_t e;
        rom_wr(10'h030, 8'hFF);
        rom_wr(10'h0FF, 8'h00);
        rom_wr(10'h307, 8'h0F);
        rom_wr(10'h3FF, 8'h55);
        run_pixel(9'h007, 1'b0, cmp, e);
        n_chk++;
        if (!cmp || POUT !== 12'hF0B || POUT_VLD !== 1'b1 || LOADED !== 1'b1) begin
            n_err++;
            $display("FAIL ignored_ranges: POUT=%h VLD=%b LOADED=%b expected F0B/1/1", POUT, POUT_VLD, LOADED);
        end
    endtask

    task automatic test_restart();
        bit   cmp;
        exp_t e;
        rom_wr(10'h000, 8'h3C);
        n_chk++;
        if (LOADED !== 1'b0) begin
            n_err++;
            $display("FAIL restart_loaded: LOADED=%b expected 0", LOADED);
        end
        step(1'b0, 9'h000, 1'b0, 1'b0, 10'h000, 8'h00, cmp, e);
        n_chk++;
        if (POUT !== 12'h000 || POUT_VLD !== 1'b0) begin
            n_err++;
            $display("FAIL restart_black: POUT=%h VLD=%b expected 000/0", POUT, POUT_VLD);
        end
        rom_wr(10'h3FF, 8'hAA);
        run_pixel(9'h007, 1'b0, cmp, e);
        n_chk++;
        if (!cmp || POUT !== 12'h000 || POUT_VLD !== 1'b0 || LOADED !== 1'b0) begin
            n_err++;
            $display("FAIL filling_black: POUT=%h VLD=%b LOADED=%b expected 000/0/0", POUT, POUT_VLD, LOADED);
        end
        rom_wr(10'h2FF, 8'h09);
        n_chk++;
        if (LOADED !== 1'b1) begin
            n_err++;
            $display("FAIL reload_done: LOADED=%b expected 1", LOADED);
        end
        run_pixel(9'h007, 1'b0, cmp, e);
        n_chk++;
        if (!cmp || POUT !== 12'hF0B || POUT_VLD !== 1'b1) begin
            n_err++;
            $display("FAIL reload_colour: POUT=%h VLD=%b expected F0B/1", POUT, POUT_VLD);
        end
    endtask

    task automatic test_reset_mid();
        bit   cmp;
        exp_t e;
        run_pixel(9'h005, 1'b0, cmp, e);
        reset = 1'b1;
        #2;
        n_chk++;
        if (POUT !== 12'h000 || POUT_VLD !== 1'b0 || LOADED !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid: POUT=%h VLD=%b LOADED=%b expected 000/0/1", POUT, POUT_VLD, LOADED);
        end
        @(posedge clk48M);
        #1;
        reset = 1'b0;
        pipe_unknown();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 9'($urandom), 1'b0, 1'b0, 10'h000, 8'h00, cmp, e);
            if (cmp) begin
                n_chk++;
                if (POUT !== e.pout || POUT_VLD !== e.vld) begin
                    n_err++;
                    $display("FAIL after_reset[%0d]: POUT=%h VLD=%b expected %h/%b", i, POUT, POUT_VLD, e.pout, e.vld);
                end
            end
        end
    endtask

    initial begin
        pipe_unknown();
        test_powerup();
        test_reset();
        test_download_fill();
        test_transparent();
        test_pce_hold();
        test_random_stream();
        test_write_race();
        test_ignored();
        test_restart();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
